// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the decoupled instruction-fetch queue.
//   FQ_XLEN      : word width the entry record is built for
//   FQ_RESET_PC  : default first fetch address after reset
//   FQ_NOP_INST  : default instruction presented when the queue is empty
//   fq_state_t   : fetch FSM states (FETCH issues, FLUSH drains stale responses)
//   fq_entry_t   : one queue entry {inst, pc, pcPlus4}
//   fq_sat_inc() : saturating 32-bit event-counter increment
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int          FQ_XLEN     = 32;
    localparam logic [31:0] FQ_RESET_PC = 32'h0001_0000;
    localparam logic [31:0] FQ_NOP_INST = 32'h0000_0013;

    typedef enum logic {
        FQ_FETCH = 1'b0,
        FQ_FLUSH = 1'b1
    } fq_state_t;

    typedef struct packed {
        logic [FQ_XLEN-1:0] inst;
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] pcPlus4;
    } fq_entry_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] fq_sat_inc(input logic [31:0] value,
                                               input logic        event_hit);
        return (event_hit && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
    endfunction

endpackage : fetch_pkg

// File: rtl/fq_ring.sv
// -----------------------------------------------------------------------------
// fq_ring
// Generic DEPTH x W register ring buffer with push, pop, clear and occupancy.
//   clk      : clock, all state on rising edge
//   reset    : synchronous active-high reset of pointers and occupancy
//   clear_i  : drop every entry; wins over push and pop in the same cycle
//   push_i   : write wdata_i at the tail (ignored when full and not popping)
//   wdata_i  : data to write
//   pop_i    : retire the head entry (ignored when empty)
//   head_o   : head entry, read straight from storage
//   count_o  : number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fq_ring
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A push at full is only legal when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latch).
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule : fq_ring

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Decoupled instruction-fetch front end: issues in-order requests to a
// variable-latency imem port, buffers up to DEPTH returned instructions with
// their PC and PC+4, and hands the head to ID over a valid/ready handshake.
// A redirect flushes the queue and drops responses still in flight.
//
// Ports
//   clk, reset          : clock; synchronous active-high reset
//   i_redirect          : flush and restart fetch at i_redirectPC (bit 0 cleared)
//   o_imemReq/Addr      : request valid / address
//   i_imemGnt           : request accepted this cycle
//   i_imemRvalid/Rdata  : in-order response valid / instruction
//   o_valid             : head entry valid to ID
//   o_inst/o_PC/o_PCPlus4 : head entry (NOP_INST / 0 / 0 when empty)
//   i_ready             : ID accepts the head
//   o_empty, o_full     : queue occupancy flags
// Optional (FETCH_QUEUE_STATS_EN defined):
//   o_statStall         : cycles with o_valid && !i_ready
//   o_statEmpty         : cycles with o_empty while in FETCH
//   o_statFlush         : number of redirects
// All statistics saturate at 32'hFFFF_FFFF and reset to 0.
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = FQ_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = FQ_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INST = FQ_NOP_INST
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirectPC,
    output logic            o_imemReq,
    output logic [XLEN-1:0] o_imemAddr,
    input  logic            i_imemGnt,
    input  logic            i_imemRvalid,
    input  logic [XLEN-1:0] i_imemRdata,
    output logic            o_valid,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_PC,
    output logic [XLEN-1:0] o_PCPlus4,
    input  logic            i_ready,
    output logic            o_empty,
    output logic            o_full
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]     o_statStall,
    output logic [31:0]     o_statEmpty,
    output logic [31:0]     o_statFlush
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    // The entry record in the package is fixed at FQ_XLEN bits.
    if (XLEN != FQ_XLEN) begin : g_xlen_check
        $error("fetch_queue: XLEN must equal FQ_XLEN");
    end

    fq_state_t       state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [CW-1:0]   entry_count, shadow_count;
    fq_entry_t       entry_head, entry_wdata;
    logic [XLEN-1:0] shadow_head;
    logic [CW:0]     credit_used;
    logic            issue, resp_kept, resp_drop, enq, deq;

    // Credit rule: entries held plus requests in flight never exceed DEPTH,
    // so every kept response is guaranteed a free slot.
    assign credit_used = {1'b0, entry_count} + {1'b0, outst_q};
    assign o_imemReq   = (state_q == FQ_FETCH) && !reset && !i_redirect &&
                         (credit_used < (CW+1)'(DEPTH));
    assign o_imemAddr  = fetch_pc_q;
    assign issue       = o_imemReq && i_imemGnt;

    // A response with no recorded address is never enqueued.
    assign resp_kept = i_imemRvalid && (discard_q == '0) && (shadow_count != '0);
    assign resp_drop = i_imemRvalid && (discard_q != '0);
    assign enq       = resp_kept && !i_redirect;
    assign deq       = o_valid && i_ready && !i_redirect;

    assign entry_wdata = '{inst:    i_imemRdata,
                           pc:      shadow_head,
                           pcPlus4: shadow_head + XLEN'(4)};

    // Instruction queue handed to ID.
    fq_ring #(
        .DEPTH (DEPTH),
        .W     ($bits(fq_entry_t))
    ) u_entry_ring (
        .clk     (clk),
        .reset   (reset),
        .clear_i (i_redirect),
        .push_i  (enq),
        .wdata_i (entry_wdata),
        .pop_i   (deq),
        .head_o  (entry_head),
        .count_o (entry_count)
    );

    // Addresses of issued requests, matched to responses in order. Stale
    // responses after a redirect find it empty, so only kept ones pop it.
    fq_ring #(
        .DEPTH (DEPTH),
        .W     (XLEN)
    ) u_shadow_ring (
        .clk     (clk),
        .reset   (reset),
        .clear_i (i_redirect),
        .push_i  (issue),
        .wdata_i (fetch_pc_q),
        .pop_i   (resp_kept),
        .head_o  (shadow_head),
        .count_o (shadow_count)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        outst_d    = outst_q;

        if (issue)        outst_d = outst_d + CW'(1);
        if (i_imemRvalid) outst_d = outst_d - CW'(1);

        if (i_redirect) begin
            // No issue happens this cycle, so outst_d already is "in flight
            // after this response": exactly the responses that must be dropped.
            fetch_pc_d = {i_redirectPC[XLEN-1:1], 1'b0};
            discard_d  = outst_d;
            state_d    = (outst_d != '0) ? FQ_FLUSH : FQ_FETCH;
        end else begin
            if (issue)     fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (resp_drop) discard_d  = discard_q - CW'(1);
            if ((state_q == FQ_FLUSH) && (discard_d == '0)) state_d = FQ_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FQ_FETCH;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    assign o_valid   = (entry_count != '0);
    assign o_empty   = (entry_count == '0);
    assign o_full    = (entry_count == CW'(DEPTH));
    assign o_inst    = o_valid ? entry_head.inst    : NOP_INST;
    assign o_PC      = o_valid ? entry_head.pc      : '0;
    assign o_PCPlus4 = o_valid ? entry_head.pcPlus4 : '0;

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stat_stall_q, stat_empty_q, stat_flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_stall_q <= '0;
            stat_empty_q <= '0;
            stat_flush_q <= '0;
        end else begin
            stat_stall_q <= fq_sat_inc(stat_stall_q, o_valid && !i_ready);
            stat_empty_q <= fq_sat_inc(stat_empty_q, o_empty && (state_q == FQ_FETCH));
            stat_flush_q <= fq_sat_inc(stat_flush_q, i_redirect);
        end
    end

    assign o_statStall = stat_stall_q;
    assign o_statEmpty = stat_empty_q;
    assign o_statFlush = stat_flush_q;
`endif

endmodule : fetch_queue

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end that replaces the single PC register plus IF/ID latch of the 5-stage core with a decoupled prefetch queue.
- Issues in-order requests to an imem port with variable latency and buffers up to DEPTH returned instructions with their PC and PC+4.
- Presents the head entry to the ID stage through a valid/ready handshake.
- A redirect (branch, jalr, trap, mret) flushes the queue and discards in-flight responses.

Parameters:
- XLEN, 32, width of PC and instruction words.
- DEPTH, 4, queue entries and maximum outstanding requests; power of two, >=2.
- RESET_PC, 32'h0001_0000, PC fetched first after reset.
- NOP_INST, 32'h0000_0013, instruction driven on o_inst when the queue is empty (addi x0,x0,0).

Ports:
- clk, input, 1, single clock, all state on rising edge.
- reset, input, 1, reset is synchronous and active-high.
- i_redirect, input, 1, flush and restart fetch at i_redirectPC.
- i_redirectPC, input, XLEN, new fetch PC; bit 0 forced to 0.
- o_imemReq, output, 1, request valid.
- o_imemAddr, output, XLEN, request address.
- i_imemGnt, input, 1, request accepted this cycle.
- i_imemRvalid, input, 1, response valid; responses return in request order.
- i_imemRdata, input, XLEN, response instruction.
- o_valid, output, 1, head entry valid to ID.
- o_inst, output, XLEN, head instruction; NOP_INST when empty.
- o_PC, output, XLEN, head PC.
- o_PCPlus4, output, XLEN, head PC+4.
- i_ready, input, 1, ID accepts the head (~Di_stall).
- o_empty, output, 1, queue has no entries.
- o_full, output, 1, count == DEPTH.

Behaviour:
- Reset: state=FETCH, fetchPC=RESET_PC, count=0, outstanding=0, discard=0, rd/wr pointers=0.
- Reset output values: o_imemReq=0, o_valid=0, o_inst=NOP_INST, o_PC=0, o_PCPlus4=0, o_empty=1, o_full=0.
- Reset mid-operation overrides everything, including a concurrent i_redirect. Responses arriving after reset are ignored only if the imem port is also reset; that is the integration contract.
- Issue:
  - o_imemReq=1 when state==FETCH, !reset and (count+outstanding)<DEPTH.
  - o_imemAddr=fetchPC.
  - On req&gnt: fetchPC+=4 (wraps modulo 2^XLEN), outstanding+=1.
- Response:
  - When i_imemRvalid and discard==0: write {rdata, pc, pc+4} at wrptr, count+=1, outstanding-=1.
  - The pc of each entry comes from a DEPTH-deep shadow FIFO of issued addresses, popped on every response.
  - When discard>0: response dropped, discard-=1, outstanding-=1.
- Dequeue: on o_valid&i_ready, rdptr+=1, count-=1.
  - Simultaneous enqueue and dequeue keeps count unchanged, including at full.
  - Enqueue never overflows by construction (credit rule).
- Output timing:
  - o_valid=(count!=0); o_inst/o_PC/o_PCPlus4 are registered-storage reads of the head, zero combinational path from i_imemRdata.
  - Minimum latency gnt->o_valid is 1 cycle after rvalid.
- Pointers are $clog2(DEPTH) bits and wrap naturally; count/outstanding/discard are $clog2(DEPTH+1) bits.
- Redirect (highest priority after reset):
  - Next cycle count=0, fetchPC={i_redirectPC[XLEN-1:1],1'b0}, shadow FIFO cleared.
  - discard_next = outstanding_next, where outstanding_next includes this cycle's response decrement; no request is issued in the redirect cycle (o_imemReq forced 0).
  - Dequeue and enqueue in the redirect cycle are void.
  - State -> FLUSH if discard_next>0, else FETCH.
- FSM:
  - FETCH: normal issue.
  - FLUSH: no issue; -> FETCH when discard reaches 0.
  - A redirect in FLUSH re-arms discard with the remaining outstanding value and updates fetchPC.

Optional Feature:
- FETCH_QUEUE_STATS_EN defined: adds outputs o_statStall (32b, cycles with o_valid&!i_ready), o_statEmpty (32b, cycles with o_empty and state==FETCH), o_statFlush (32b, redirect count). All saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; no other behaviour changes.

Decomposition:
- Shared package fetch_pkg:
  - localparam NOP_INST and RESET_PC defaults.
  - typedef fq_state_t {FQ_FETCH, FQ_FLUSH}.
  - typedef fq_entry_t {inst, pc, pcPlus4}.
- One sub-module: fq_ring, a generic DEPTH x W register ring with push/pop/clear and count. Instantiated twice: the entry queue and the issued-address shadow FIFO.

Test Plan:
- Reset, i_imemGnt=1, 1-cycle response, i_ready=1 -> o_imemAddr 0x10000,0x10004,0x10008...; o_PC sequence identical, o_PCPlus4=o_PC+4, o_valid steady after startup.
- i_ready=0 with DEPTH=4 -> exactly 4 grants, o_full=1, o_imemReq=0; release i_ready -> one request per dequeue, no lost or duplicated PC.
- 3 outstanding, redirect to 0x2001 -> o_empty next cycle, state FLUSH, next 3 responses dropped, first new request at 0x2000, o_PC=0x2000.
- Redirect in the same cycle as rvalid and o_valid&i_ready with outstanding=2 -> discard=1, the current response is not enqueued, count=0.
- Empty queue -> o_inst=32'h13, o_valid=0; fetchPC=32'hFFFF_FFFC grant -> next address 0x0.
- Reset asserted during FLUSH with discard=2 -> next cycle FETCH, o_imemAddr=0x10000, all counters 0. With FETCH_QUEUE_STATS_EN, 5 redirects -> o_statFlush=5.
